// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_pkg
//  Description : Shared constants for the next-PC / branch-prediction unit.
//                The NPC op encodings match defines.vh. The package also
//                holds the 2-bit saturating counter states and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

  // Next-PC operation select coming down from EX
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_JAL  = 2'd1;
  localparam logic [1:0] NPC_JALR = 2'd2;
  localparam logic [1:0] NPC_JMP  = 2'd3;

  // 2-bit saturating counter states; the MSB is the taken prediction
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/npc_btb.sv
`default_nettype none
// ============================================================================
//  Module      : npc_btb
//  Description : Direct-mapped branch target buffer with 2-bit counters.
//                Read port  : rd_idx/rd_tag -> rd_taken, rd_target (comb).
//                Write port : wr_en, wr_idx, wr_tag, wr_taken, wr_uncond,
//                             wr_target; applied at the rising clock edge.
//                clk / rst_n : clock, synchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_btb
  import npc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16,
  localparam int IW       = $clog2(BTB_DEPTH),
  localparam int TW       = XLEN - IW - 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IW-1:0]   rd_idx,
  input  logic [TW-1:0]   rd_tag,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [TW-1:0]   wr_tag,
  input  logic            wr_taken,
  input  logic            wr_uncond,
  input  logic [XLEN-1:0] wr_target
);

  logic            valid_q  [BTB_DEPTH];
  logic            valid_d  [BTB_DEPTH];
  logic [TW-1:0]   tag_q    [BTB_DEPTH];
  logic [TW-1:0]   tag_d    [BTB_DEPTH];
  logic [1:0]      ctr_q    [BTB_DEPTH];
  logic [1:0]      ctr_d    [BTB_DEPTH];
  logic [XLEN-1:0] target_q [BTB_DEPTH];
  logic [XLEN-1:0] target_d [BTB_DEPTH];
  logic            wr_hit;

  // Lookup reads only the registered state, so a same-cycle update to the
  // same index is seen by the next lookup, not this one.
  assign rd_taken  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && ctr_q[rd_idx][1];
  assign rd_target = target_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    if (wr_en) begin
      if (wr_hit) begin
        if (wr_taken) begin
          // Unconditional jumps always resolve taken, so pin them strong
          ctr_d[wr_idx]    = wr_uncond ? CTR_ST : ctr_inc(ctr_q[wr_idx]);
          target_d[wr_idx] = wr_target;
        end else begin
          ctr_d[wr_idx] = ctr_dec(ctr_q[wr_idx]);
        end
      end else if (wr_taken) begin
        // Allocate (or evict an alias); not-taken misses are not worth a slot
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = wr_target;
        ctr_d[wr_idx]    = wr_uncond ? CTR_ST : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_WNT;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      ctr_q    <= ctr_d;
      target_q <= target_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/npc_bpred.sv
`default_nettype none
// ============================================================================
//  Module      : npc_bpred
//  Description : Next-PC unit with BTB-based branch prediction. Owns the
//                fetch PC, predicts redirects from the BTB and resolves
//                JAL/JALR/branch outcomes from EX, flushing on mispredict.
//  Ports       : clk, rst_n (sync active-low), stall
//                IF side : if_pc, if_pc4, if_pred_taken, if_pred_target
//                EX side : ex_valid, ex_pc, ex_npc_op, ex_br, ex_offset,
//                          ex_imm, ex_pred_taken, ex_pred_target
//                flush   : mispredict, kill IF/ID this cycle
//  Options     : NPC_PERF_CNT_EN adds perf_ctl_cnt and perf_mispred_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_bpred
  import npc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [1:0]      ex_npc_op,
  input  logic            ex_br,
  input  logic [XLEN-1:0] ex_offset,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush
`ifdef NPC_PERF_CNT_EN
  ,
  output logic [31:0]     perf_ctl_cnt,
  output logic [31:0]     perf_mispred_cnt
`endif
);

  localparam int IW = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - IW - 2;

  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;
  logic            act_taken;
  logic [XLEN-1:0] act_target;
  logic            mispredict;
  logic            btb_wr_en;

  assign if_pc          = if_pc_q;
  assign if_pc4         = if_pc_q + XLEN'(4);
  assign if_pred_taken  = btb_taken;
  assign if_pred_target = btb_taken ? btb_target : if_pc4;

  // ---------------------------------------------------------------- resolve
  always_comb begin
    act_taken  = 1'b0;
    act_target = ex_pc + ex_offset;
    case (ex_npc_op)
      NPC_JAL:  act_taken = 1'b1;
      NPC_JALR: begin
        act_taken  = 1'b1;
        act_target = ex_imm & ~XLEN'(1);
      end
      NPC_JMP:  act_taken = ex_br;
      default:  act_taken = 1'b0;
    endcase
  end

  assign mispredict = (act_taken != ex_pred_taken) ||
                      (act_taken && (act_target != ex_pred_target));
  assign flush      = rst_n && ex_valid && mispredict;
  assign btb_wr_en  = ex_valid && (ex_npc_op != NPC_PC4);

  // ------------------------------------------------------------- PC update
  always_comb begin
    if_pc_d = if_pc4;
    if (flush)
      if_pc_d = act_taken ? act_target : ex_pc + XLEN'(4);
    else if (stall)
      if_pc_d = if_pc_q;
    else if (if_pred_taken)
      if_pc_d = if_pred_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) if_pc_q <= RESET_PC;
    else        if_pc_q <= if_pc_d;
  end

  // -------------------------------------------------------------------- BTB
  npc_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc_q[IW+1:2]),
    .rd_tag    (if_pc_q[XLEN-1:IW+2]),
    .rd_taken  (btb_taken),
    .rd_target (btb_target),
    .wr_en     (btb_wr_en),
    .wr_idx    (ex_pc[IW+1:2]),
    .wr_tag    (ex_pc[XLEN-1:IW+2]),
    .wr_taken  (act_taken),
    .wr_uncond (ex_npc_op != NPC_JMP),
    .wr_target (act_target)
  );

`ifdef NPC_PERF_CNT_EN
  logic [31:0] perf_ctl_cnt_q, perf_ctl_cnt_d;
  logic [31:0] perf_mispred_cnt_q, perf_mispred_cnt_d;

  always_comb begin
    perf_ctl_cnt_d     = perf_ctl_cnt_q + {31'd0, btb_wr_en};
    perf_mispred_cnt_d = perf_mispred_cnt_q + {31'd0, flush};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ctl_cnt_q     <= '0;
      perf_mispred_cnt_q <= '0;
    end else begin
      perf_ctl_cnt_q     <= perf_ctl_cnt_d;
      perf_mispred_cnt_q <= perf_mispred_cnt_d;
    end
  end

  assign perf_ctl_cnt     = perf_ctl_cnt_q;
  assign perf_mispred_cnt = perf_mispred_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npc_bpred.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npc_bpred
//  Description : Directed self-checking bench for npc_bpred (RESET_PC=0x100,
//                BTB_DEPTH=16, XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_bpred;

  localparam logic [1:0] OP_PC4  = 2'd0;
  localparam logic [1:0] OP_JAL  = 2'd1;
  localparam logic [1:0] OP_JALR = 2'd2;
  localparam logic [1:0] OP_JMP  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] if_pc, if_pc4, if_pred_target;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_npc_op;
  logic        ex_br;
  logic [31:0] ex_offset, ex_imm, ex_pred_target;
  logic        ex_pred_taken;
  logic        flush;
`ifdef NPC_PERF_CNT_EN
  logic [31:0] perf_ctl_cnt, perf_mispred_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  npc_bpred #(
    .XLEN      (32),
    .BTB_DEPTH (16),
    .RESET_PC  (32'h100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_npc_op      (ex_npc_op),
    .ex_br          (ex_br),
    .ex_offset      (ex_offset),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush)
`ifdef NPC_PERF_CNT_EN
    ,
    .perf_ctl_cnt     (perf_ctl_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic [31:0] pc, input logic [1:0] op, input logic br,
                          input logic [31:0] off, input logic [31:0] imm,
                          input logic ptaken, input logic [31:0] ptarget);
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_npc_op      = op;
    ex_br          = br;
    ex_offset      = off;
    ex_imm         = imm;
    ex_pred_taken  = ptaken;
    ex_pred_target = ptarget;
  endtask

  // Force fetch to addr: a predicted-taken branch at addr-4 that resolves
  // not taken. A BTB miss on a not-taken branch leaves the BTB alone.
  task automatic redirect(input logic [31:0] addr);
    ex_drive(addr - 32'd4, OP_JMP, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
    step();
    ex_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    ex_drive(32'h200, OP_JAL, 1'b0, 32'h40, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_in_reset got=%b exp=0", flush); end
    step();
    step();
    ex_valid = 1'b0;
    checks++; if (if_pc !== 32'h100) begin errors++; $display("FAIL reset_pc got=%h exp=00000100", if_pc); end
    rst_n = 1'b1;
    #1;
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", if_pred_taken); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (if_pc4 !== 32'h104) begin errors++; $display("FAIL reset_pc4 got=%h exp=00000104", if_pc4); end
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if (if_pc !== 32'h100 + 32'(4 * i)) begin
        errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, if_pc, 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if_pc !== 32'h108) begin errors++; $display("FAIL stall_hold%0d got=%h exp=00000108", i, if_pc); end
    end
    stall = 1'b0;
    step();
    checks++; if (if_pc !== 32'h10C) begin errors++; $display("FAIL stall_release got=%h exp=0000010c", if_pc); end
  endtask

  task automatic test_jal();
    ex_drive(32'h200, OP_JAL, 1'b0, 32'h40, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jal_flush got=%b exp=1", flush); end
    step();
    ex_valid = 1'b0;
    checks++; if (if_pc !== 32'h240) begin errors++; $display("FAIL jal_pc got=%h exp=00000240", if_pc); end
    redirect(32'h200);
    checks++; if (if_pc !== 32'h200) begin errors++; $display("FAIL jal_refetch got=%h exp=00000200", if_pc); end
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL jal_pred got=%b exp=1", if_pred_taken); end
    checks++; if (if_pred_target !== 32'h240) begin errors++; $display("FAIL jal_ptgt got=%h exp=00000240", if_pred_target); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jal_noflush got=%b exp=0", flush); end
    step();
    checks++; if (if_pc !== 32'h240) begin errors++; $display("FAIL jal_predpc got=%h exp=00000240", if_pc); end
  endtask

  task automatic test_jmp();
    // first taken: allocate weakly taken
    ex_drive(32'h300, OP_JMP, 1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jmp1_flush got=%b exp=1", flush); end
    step();
    ex_valid = 1'b0;
    checks++; if (if_pc !== 32'h2F0) begin errors++; $display("FAIL jmp1_pc got=%h exp=000002f0", if_pc); end
    redirect(32'h300);
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL jmp1_pred got=%b exp=1", if_pred_taken); end
    checks++; if (if_pred_target !== 32'h2F0) begin errors++; $display("FAIL jmp1_ptgt got=%h exp=000002f0", if_pred_target); end
    // second taken, correctly predicted: ctr 10 -> 11
    ex_drive(32'h300, OP_JMP, 1'b1, 32'hFFFF_FFF0, 32'd0, 1'b1, 32'h2F0);
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jmp2_flush got=%b exp=0", flush); end
    step();
    ex_valid = 1'b0;
    checks++; if (if_pc !== 32'h2F0) begin errors++; $display("FAIL jmp2_pc got=%h exp=000002f0", if_pc); end
    // not taken: 11 -> 10, still predicts taken
    redirect(32'h300);
    ex_drive(32'h300, OP_JMP, 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b1, 32'h2F0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jmp3_flush got=%b exp=1", flush); end
    step();
    ex_valid = 1'b0;
    checks++; if (if_pc !== 32'h304) begin errors++; $display("FAIL jmp3_pc got=%h exp=00000304", if_pc); end
    redirect(32'h300);
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL jmp3_pred got=%b exp=1", if_pred_taken); end
    // not taken again: 10 -> 01, now predicts fall-through
    ex_drive(32'h300, OP_JMP, 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b1, 32'h2F0);
    step();
    ex_valid = 1'b0;
    redirect(32'h300);
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL jmp4_pred got=%b exp=0", if_pred_taken); end
    checks++; if (if_pred_target !== 32'h304) begin errors++; $display("FAIL jmp4_ptgt got=%h exp=00000304", if_pred_target); end
  endtask

  task automatic test_jalr();
    ex_drive(32'h500, OP_JALR, 1'b0, 32'd0, 32'h1235, 1'b1, 32'h1234);
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jalr_ok_flush got=%b exp=0", flush); end
    step();
    ex_drive(32'h500, OP_JALR, 1'b0, 32'd0, 32'h1235, 1'b1, 32'h1238);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_bad_flush got=%b exp=1", flush); end
    step();
    ex_valid = 1'b0;
    checks++; if (if_pc !== 32'h1234) begin errors++; $display("FAIL jalr_pc got=%h exp=00001234", if_pc); end
  endtask

  task automatic test_flush_stall();
    stall = 1'b1;
    ex_drive(32'h600, OP_JAL, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fs_flush got=%b exp=1", flush); end
    step();
    ex_valid = 1'b0;
    stall    = 1'b0;
    checks++; if (if_pc !== 32'h620) begin errors++; $display("FAIL fs_pc got=%h exp=00000620", if_pc); end
  endtask

  task automatic test_alias();
    ex_drive(32'h0, OP_JAL, 1'b0, 32'h80, 32'd0, 1'b0, 32'd0);
    step();
    ex_valid = 1'b0;
    redirect(32'h40);
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_miss got=%b exp=0", if_pred_taken); end
    checks++; if (if_pred_target !== 32'h44) begin errors++; $display("FAIL alias_ptgt got=%h exp=00000044", if_pred_target); end
    ex_drive(32'h40, OP_JAL, 1'b0, 32'h100, 32'd0, 1'b0, 32'd0);
    step();
    ex_valid = 1'b0;
    redirect(32'h0);
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evict got=%b exp=0", if_pred_taken); end
    redirect(32'h40);
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new got=%b exp=1", if_pred_taken); end
    checks++; if (if_pred_target !== 32'h140) begin errors++; $display("FAIL alias_ntgt got=%h exp=00000140", if_pred_target); end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=fffffffc", if_pc); end
    checks++; if (if_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=00000000", if_pc4); end
    step();
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=00000000", if_pc); end
  endtask

  task automatic test_reset_mid();
    ex_drive(32'h80, OP_JAL, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rmid_flush got=%b exp=0", flush); end
    step();
    rst_n    = 1'b1;
    ex_valid = 1'b0;
    #1;
    checks++; if (if_pc !== 32'h100) begin errors++; $display("FAIL rmid_pc got=%h exp=00000100", if_pc); end
    redirect(32'h40);
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL rmid_btb40 got=%b exp=0", if_pred_taken); end
    redirect(32'h80);
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL rmid_btb80 got=%b exp=0", if_pred_taken); end
  endtask

  initial begin
    ex_valid = 1'b0; ex_pc = '0; ex_npc_op = OP_PC4; ex_br = 1'b0;
    ex_offset = '0; ex_imm = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    test_reset();
    test_stall();
    test_jal();
    test_jmp();
    test_jalr();
    test_flush_stall();
    test_alias();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
